// File: rtl/inst_cache_if.sv
// Handshake bundle between the instruction fetcher, the instruction cache and the memory controller.
// The slave modport is the cache's view; the master modport is the surrounding fetcher/controller.
interface inst_cache_if #(
    parameter int ADDR_W = 32
);
    logic              clear;
    logic [ADDR_W-1:0] addr_from_fetcher;
    logic              valid_from_fetcher;
    logic              ready_to_fetcher;
    logic [31:0]       data_to_fetcher;
    logic [ADDR_W-1:0] addr_to_mem_ctrler;
    logic              valid_to_mem_ctrler;
    logic [127:0]      data_from_mem_ctrler;
    logic              ready_from_mem_ctrler;

    modport slave (
        input  clear, addr_from_fetcher, valid_from_fetcher,
        input  data_from_mem_ctrler, ready_from_mem_ctrler,
        output ready_to_fetcher, data_to_fetcher,
        output addr_to_mem_ctrler, valid_to_mem_ctrler
    );

    modport master (
        output clear, addr_from_fetcher, valid_from_fetcher,
        output data_from_mem_ctrler, ready_from_mem_ctrler,
        input  ready_to_fetcher, data_to_fetcher,
        input  addr_to_mem_ctrler, valid_to_mem_ctrler
    );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with 16-byte lines and a single outstanding refill.
// All outputs are registered; rdy low freezes every register.
module inst_cache #(
    parameter int INDEX_BITS = 4,
    parameter int ADDR_W     = 32
) (
    input logic         clk,
    input logic         rst,
    input logic         rdy,
    inst_cache_if.slave bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - 4 - INDEX_BITS;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                  state;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [127:0]            data_q [LINES];
    logic                    aborted;
    logic [1:0]              word_q;
    logic                    ready_q;
    logic [31:0]             data_out_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic                    mem_valid_q;

    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [1:0]              req_word;
    logic [INDEX_BITS-1:0]   fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    hit;
    logic                    fill;

    assign req_idx  = bus.addr_from_fetcher[4 +: INDEX_BITS];
    assign req_tag  = bus.addr_from_fetcher[ADDR_W-1 -: TAG_W];
    assign req_word = bus.addr_from_fetcher[3:2];
    assign fill_idx = mem_addr_q[4 +: INDEX_BITS];
    assign fill_tag = mem_addr_q[ADDR_W-1 -: TAG_W];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign fill     = (state == MISS) && bus.ready_from_mem_ctrler;

    // Tag and data arrays carry no reset; the valid bits alone decide residency.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.data_from_mem_ctrler;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            valid_q     <= '0;
            aborted     <= 1'b0;
            word_q      <= 2'd0;
            ready_q     <= 1'b0;
            data_out_q  <= 32'd0;
            mem_addr_q  <= '0;
            mem_valid_q <= 1'b0;
        end else if (rdy) begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    aborted <= 1'b0;
                    // While a response is out the fetcher is changing its request, so skip that cycle.
                    if (bus.valid_from_fetcher && !ready_q && !bus.clear) begin
                        if (hit) begin
                            data_out_q <= data_q[req_idx][{req_word, 5'b0} +: 32];
                            ready_q    <= 1'b1;
                        end else begin
                            mem_addr_q  <= {req_tag, req_idx, 4'b0};
                            mem_valid_q <= 1'b1;
                            word_q      <= req_word;
                            state       <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (bus.clear)
                        aborted <= 1'b1;
                    // The refill always completes and installs; only the response is suppressed on abort.
                    if (bus.ready_from_mem_ctrler) begin
                        valid_q[fill_idx] <= 1'b1;
                        mem_valid_q       <= 1'b0;
                        state             <= IDLE;
                        if (!aborted && !bus.clear) begin
                            data_out_q <= bus.data_from_mem_ctrler[{word_q, 5'b0} +: 32];
                            ready_q    <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready_to_fetcher    = ready_q;
    assign bus.data_to_fetcher     = data_out_q;
    assign bus.addr_to_mem_ctrler  = mem_addr_q;
    assign bus.valid_to_mem_ctrler = mem_valid_q;
endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios plus random fetches against a
// resident-line table model; the bench also plays the memory controller.
module tb_inst_cache;
    logic clk;
    logic rst;
    logic rdy;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        ref_valid [16];
    logic [23:0] ref_tag   [16];

    inst_cache_if #(.ADDR_W(32)) bus ();

    inst_cache #(.INDEX_BITS(4), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backing memory contents: word w of the line at la; line 0 reads 0,1111_1111,2222_2222,3333_3333.
    function automatic logic [31:0] mem_word(input logic [31:0] la, input logic [1:0] w);
        return (32'h1111_1111 * {30'd0, w}) ^ la ^ (la << 7);
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        return {mem_word(la, 2'd3), mem_word(la, 2'd2), mem_word(la, 2'd1), mem_word(la, 2'd0)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic valid, input logic clr);
        bus.addr_from_fetcher  = a;
        bus.valid_from_fetcher = valid;
        bus.clear              = clr;
    endtask

    task automatic ref_install(input logic [31:0] a);
        ref_valid[a[7:4]] = 1'b1;
        ref_tag[a[7:4]]   = a[31:8];
    endtask

    function automatic logic ref_hit(input logic [31:0] a);
        return ref_valid[a[7:4]] && (ref_tag[a[7:4]] == a[31:8]);
    endfunction

    // Drive line data for one cycle; called at a negedge, ends at the negedge after the capturing edge.
    task automatic mem_respond(input logic [31:0] la, input logic clr);
        bus.data_from_mem_ctrler  = mem_line(la);
        bus.ready_from_mem_ctrler = 1'b1;
        bus.clear                 = clr;
        @(negedge clk);
        bus.ready_from_mem_ctrler = 1'b0;
        bus.clear                 = 1'b0;
    endtask

    // Full fetch; hit or miss is predicted by the model and every observable step is checked.
    task automatic fetch(input logic [31:0] a, input int lat);
        logic [31:0] la;
        la = {a[31:4], 4'b0};
        applyStimulus(a, 1'b1, 1'b0);
        @(negedge clk);
        if (ref_hit(a)) begin
            checkOutput("hit_ready", {31'd0, bus.ready_to_fetcher}, 32'd1);
            checkOutput("hit_data", bus.data_to_fetcher, mem_word(la, a[3:2]));
            checkOutput("hit_no_req", {31'd0, bus.valid_to_mem_ctrler}, 32'd0);
        end else begin
            checkOutput("miss_req", {31'd0, bus.valid_to_mem_ctrler}, 32'd1);
            checkOutput("miss_addr", bus.addr_to_mem_ctrler, la);
            checkOutput("miss_no_ready", {31'd0, bus.ready_to_fetcher}, 32'd0);
            repeat (lat) @(negedge clk);
            checkOutput("miss_req_held", {31'd0, bus.valid_to_mem_ctrler}, 32'd1);
            mem_respond(la, 1'b0);
            checkOutput("fill_ready", {31'd0, bus.ready_to_fetcher}, 32'd1);
            checkOutput("fill_data", bus.data_to_fetcher, mem_word(la, a[3:2]));
            checkOutput("fill_req_dropped", {31'd0, bus.valid_to_mem_ctrler}, 32'd0);
            ref_install(a);
        end
        applyStimulus(a, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ready_pulse_end", {31'd0, bus.ready_to_fetcher}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = 24'd0;
        end
        rst = 1'b1;
        rdy = 1'b1;
        applyStimulus(32'd0, 1'b0, 1'b0);
        bus.data_from_mem_ctrler  = 128'd0;
        bus.ready_from_mem_ctrler = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", {31'd0, bus.ready_to_fetcher}, 32'd0);
        checkOutput("rst_data", bus.data_to_fetcher, 32'd0);
        checkOutput("rst_req", {31'd0, bus.valid_to_mem_ctrler}, 32'd0);
        checkOutput("rst_addr", bus.addr_to_mem_ctrler, 32'd0);
        rst = 1'b0;

        $display("[TB] cold miss, hit after fill, conflict eviction");
        fetch(32'h0000_0004, 20);
        fetch(32'h0000_000C, 0);
        fetch(32'h0000_0100, 3);
        fetch(32'h0000_0000, 2);

        $display("[TB] abort during miss");
        a = 32'h0000_0238;
        applyStimulus(a, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("abort_req", {31'd0, bus.valid_to_mem_ctrler}, 32'd1);
        applyStimulus(a, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(a, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("abort_req_kept", {31'd0, bus.valid_to_mem_ctrler}, 32'd1);
        mem_respond({a[31:4], 4'b0}, 1'b0);
        checkOutput("abort_no_ready", {31'd0, bus.ready_to_fetcher}, 32'd0);
        checkOutput("abort_req_dropped", {31'd0, bus.valid_to_mem_ctrler}, 32'd0);
        ref_install(a);
        @(negedge clk);
        checkOutput("abort_still_quiet", {31'd0, bus.ready_to_fetcher}, 32'd0);
        fetch(a, 0);

        $display("[TB] clear together with line data");
        a = 32'h0000_1354;
        applyStimulus(a, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("clr_fill_req", {31'd0, bus.valid_to_mem_ctrler}, 32'd1);
        applyStimulus(a, 1'b0, 1'b0);
        @(negedge clk);
        mem_respond({a[31:4], 4'b0}, 1'b1);
        checkOutput("clr_fill_no_ready", {31'd0, bus.ready_to_fetcher}, 32'd0);
        checkOutput("clr_fill_req_dropped", {31'd0, bus.valid_to_mem_ctrler}, 32'd0);
        ref_install(a);
        fetch(a, 0);

        $display("[TB] rdy stall during hit response");
        a = 32'h0000_0008;
        applyStimulus(a, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("stall_ready", {31'd0, bus.ready_to_fetcher}, 32'd1);
        rdy = 1'b0;
        applyStimulus(a, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_ready_held", {31'd0, bus.ready_to_fetcher}, 32'd1);
            checkOutput("stall_data_held", bus.data_to_fetcher, mem_word(32'd0, 2'd2));
        end
        rdy = 1'b1;
        @(negedge clk);
        checkOutput("stall_ready_release", {31'd0, bus.ready_to_fetcher}, 32'd0);

        $display("[TB] reset in the middle of a miss");
        a = 32'h0000_4560;
        applyStimulus(a, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("rstmiss_req", {31'd0, bus.valid_to_mem_ctrler}, 32'd1);
        rst = 1'b1;
        applyStimulus(a, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        checkOutput("rstmiss_ready", {31'd0, bus.ready_to_fetcher}, 32'd0);
        checkOutput("rstmiss_data", bus.data_to_fetcher, 32'd0);
        checkOutput("rstmiss_req_low", {31'd0, bus.valid_to_mem_ctrler}, 32'd0);
        checkOutput("rstmiss_addr", bus.addr_to_mem_ctrler, 32'd0);
        mem_respond({a[31:4], 4'b0}, 1'b0);
        checkOutput("stray_fill_ignored", {31'd0, bus.ready_to_fetcher}, 32'd0);
        checkOutput("stray_fill_no_req", {31'd0, bus.valid_to_mem_ctrler}, 32'd0);
        fetch(a, 1);
        fetch(32'h0000_0004, 0);

        $display("[TB] random fetches");
        for (int i = 0; i < 60; i++) begin
            a = {22'd0, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom), 2'($urandom)} << 2;
            a = {a[31:8] | 24'($urandom_range(0, 1) * 24'h100), a[7:0]};
            fetch(a, int'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache between the instruction fetcher and the memory controller. Serves 32-bit instruction words to the fetcher. On a miss it requests one 16-byte line from the memory controller, installs the line, and then answers the fetcher. The memory controller owns arbitration; this block only holds a single outstanding line request.

## Interface
Parameters:
- INDEX_BITS, 4, number of index bits; the cache holds 2^INDEX_BITS lines of 128 bits each.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when low, all state and outputs hold.
- clear  in  1  fetch abort (mispredict rollback); drops the pending fetcher response.
- addr_from_fetcher  in  ADDR_W  instruction byte address; bits [1:0] are ignored.
- valid_from_fetcher  in  1  request valid; held with a stable address until ready_to_fetcher.
- ready_to_fetcher  out  1  one-cycle pulse: data_to_fetcher is valid.
- data_to_fetcher  out  32  instruction word.
- addr_to_mem_ctrler  out  ADDR_W  line address, with [3:0] = 0.
- valid_to_mem_ctrler  out  1  line request, held until ready_from_mem_ctrler.
- data_from_mem_ctrler  in  128  line data; byte k is bits [8k+7:8k], and byte 0 is the lowest address.
- ready_from_mem_ctrler  in  1  one-cycle pulse: line data valid.

## Operation
- Address split:
  - offset = addr[3:0]
  - word select = addr[3:2]
  - index = addr[4+INDEX_BITS-1:4]
  - tag = addr[ADDR_W-1:4+INDEX_BITS]
- Storage: valid-bit array (reset to 0), tag array and data array (not reset).
- State machine: IDLE, MISS.
  - **IDLE**, valid_from_fetcher=1, ready_to_fetcher=0, clear=0:
    - Hit (valid[index] and tag match): register the selected word, pulse ready_to_fetcher, stay in IDLE.
    - Miss: set addr_to_mem_ctrler = {tag,index,4'b0}, set valid_to_mem_ctrler=1, go to MISS.
  - **IDLE**, while ready_to_fetcher=1: valid_from_fetcher is ignored, because the fetcher updates its request in that cycle.
  - **MISS**, on ready_from_mem_ctrler=1:
    - Write the data, tag and valid=1 for the line.
    - Clear valid_to_mem_ctrler.
    - Drive the word selected from data_from_mem_ctrler and pulse ready_to_fetcher, unless the request was aborted.
    - Go to IDLE.
- clear:
  - In IDLE: suppresses any hit response in that cycle and clears a ready_to_fetcher being set in that cycle.
  - In MISS: sets an internal aborted flag. The refill continues and the line is still installed, but no ready_to_fetcher is produced. The flag clears on return to IDLE.
- The memory request is never withdrawn once issued, because the controller cannot cancel a line transfer.
- Simultaneous clear and ready_from_mem_ctrler in MISS: the line is installed and no response is sent.
- rst in any state:
  - State goes to IDLE, all valid bits go to 0, the aborted flag goes to 0.
  - A refill in flight is discarded. A ready_from_mem_ctrler pulse arriving after reset is ignored in IDLE.
  - The controller is reset by the same rst.
- Word selection is exact: word w = line bits [32w+31:32w].

## Timing
- Reset values of outputs:
  - ready_to_fetcher=0, data_to_fetcher=0
  - valid_to_mem_ctrler=0, addr_to_mem_ctrler=0
- Hit latency:
  - Request sampled at edge N; ready_to_fetcher is high for the cycle after N and low after N+1.
  - Back-to-back hits give at most one response every 2 cycles.
- Miss:
  - valid_to_mem_ctrler rises after edge N.
  - ready_from_mem_ctrler is sampled at edge M; ready_to_fetcher and data are valid in the cycle after M.
  - valid_to_mem_ctrler is low from the cycle after M. It must be low before the controller can re-accept a request, which guarantees no duplicate refill.
- All outputs are registered; there is no combinational path from input to output.
- rdy=0 freezes every register, including the one-cycle pulses, which stretch until rdy returns.

## Test plan
- Cold miss:
  - Stimulus: reset; fetch 0x0000_0004. The controller returns line 128'h33333333_22222222_11111111_00000000 after 20 cycles.
  - Required: valid_to_mem_ctrler with addr 0x0000_0000; then ready_to_fetcher for one cycle with data 0x11111111.
- Hit after fill:
  - Stimulus: fetch 0x0000_000C.
  - Required: ready_to_fetcher one cycle after the request with data 0x33333333; valid_to_mem_ctrler stays 0.
- Conflict eviction (INDEX_BITS=4):
  - Stimulus: fetch 0x0000_0100 (index 0, different tag), then fetch 0x0000_0000.
  - Required: two refill requests, at addr 0x100 then at addr 0x000.
- Abort during miss:
  - Stimulus: pulse clear while in MISS; then fetch the same address.
  - Required: no ready_to_fetcher after the refill; the follow-up fetch hits with 1-cycle latency.
- Simultaneous clear and ready_from_mem_ctrler:
  - Required: the line is installed, no response is sent, and the FSM returns to IDLE.
- rdy stall and reset mid-miss:
  - Stimulus: rdy=0 during the hit response; separately, rst while in MISS.
  - Required:
    - With rdy=0, ready_to_fetcher is held until rdy=1.
    - After rst in MISS: outputs are 0 and the next fetch of the same address misses again.
